miriscv_data_arbiter: RTL and testbench
=======================================

MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = round-robin on contention, 0 = fixed priority to master 0.
REQ-002 SHALL have port clk_i, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port arstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports mN_req_i, input, 1 bit, for N=0,1: master N access request.
REQ-005 SHALL have ports mN_we_i, input, 1 bit: master N write enable.
REQ-006 SHALL have ports mN_be_i, input, 4 bits: master N byte enables.
REQ-007 SHALL have ports mN_addr_i, input, 32 bits: master N byte address.
REQ-008 SHALL have ports mN_wdata_i, input, 32 bits: master N write data.
REQ-009 SHALL have ports mN_gnt_o, output, 1 bit: request of master N accepted this cycle.
REQ-010 SHALL have ports mN_rvalid_o, output, 1 bit: response for master N valid.
REQ-011 SHALL have ports mN_rdata_o, output, 32 bits: read data for master N.
REQ-012 SHALL have ports ram_req_o, ram_we_o (1 bit each), ram_be_o (4 bits), ram_addr_o and ram_wdata_o (32 bits each), all outputs: shared RAM data port.
REQ-013 SHALL have ports ram_rvalid_i (1 bit) and ram_rdata_i (32 bits), inputs: RAM response, fixed 1-cycle latency after ram_req_o.
REQ-014 SHALL have port err_o, output, 1 bit: sticky protocol error flag.

Function
REQ-015 SHALL issue grants combinationally in the same cycle as the request: mN_gnt_o = 1 only when mN_req_i = 1 and master N wins arbitration.
REQ-016 SHALL never assert m0_gnt_o and m1_gnt_o in the same cycle.
REQ-017 SHALL grant the sole requester immediately when only one master requests.
REQ-018 On contention with ROUND_ROBIN=1, SHALL grant the master not granted most recently (last_ff), and SHALL update last_ff to the granted index on every grant.
REQ-019 On contention with ROUND_ROBIN=0, SHALL always grant master 0.
REQ-020 SHALL drive ram_req_o = m0_gnt_o | m1_gnt_o; ram_we/be/addr/wdata SHALL mux from the granted master, and SHALL be all zeros when there is no grant.
REQ-021 SHALL record the owner of each issued access in a pending register (pend_vld_ff, pend_id_ff), loaded every cycle from (ram_req_o, granted index).
REQ-022 On ram_rvalid_i = 1 with pend_vld_ff = 1, SHALL assert m{pend_id_ff}_rvalid_o only and SHALL leave the other master's rvalid at 0.
REQ-023 SHALL drive ram_rdata_i onto both mN_rdata_o; rdata is qualified only by mN_rvalid_o.
REQ-024 SHALL treat write and read responses identically: every grant produces exactly one rvalid to its owner one cycle later.
REQ-025 On ram_rvalid_i = 1 with pend_vld_ff = 0, SHALL set err_o to 1, hold it at 1 until reset, and assert no mN_rvalid_o.
REQ-026 SHALL set err_o when pend_vld_ff = 1 and ram_rvalid_i = 0 in the same cycle (missed response).
REQ-027 A master not granted SHALL hold its request and attributes stable; the arbiter SHALL NOT latch ungranted requests.
REQ-028 Back-to-back grants SHALL sustain 1 access per cycle; for alternating owners, responses SHALL route correctly on consecutive cycles.

Reset
REQ-029 While arstn_i = 0: last_ff = 1 (so master 0 wins the first contention), pend_vld_ff = 0, pend_id_ff = 0, err_o = 0, mN_rvalid_o = 0.
REQ-030 Reset asserted mid-access SHALL discard the pending owner; a ram_rvalid_i in the first cycle after reset release SHALL set err_o.

Verification
REQ-031 Single requester: m1 read at addr 0x10, RAM returns 0xDEADBEEF -> m1_gnt_o = 1 in cycle 0; m1_rvalid_o = 1 and m1_rdata_o = 0xDEADBEEF in cycle 1; m0_rvalid_o = 0.
REQ-032 Contention, ROUND_ROBIN=1: both masters request continuously for 4 cycles after reset -> grants alternate m0, m1, m0, m1, and rvalids follow 1 cycle later in the same order.
REQ-033 Contention, ROUND_ROBIN=0: both masters request for 3 cycles -> m0 is granted all 3 cycles and m1_gnt_o stays 0.
REQ-034 Write with byte enables: m0 writes be=0b0011, wdata=0x12345678, addr=0x20 -> RAM sees the same values that cycle and ram_req_o = 1; m0_rvalid_o = 1 the next cycle.
REQ-035 Idle bus: no requests -> ram_req_o = 0 and ram_addr_o = 0; a spurious ram_rvalid_i = 1 sets err_o = 1, which stays 1 until arstn_i is asserted.
REQ-036 Reset mid-access: m0 is granted, then arstn_i is pulsed low before the response -> no mN_rvalid_o, last_ff = 1, err_o = 0 after reset.

Source files
------------

// File: rtl/miriscv_data_arbiter.sv
// Two-master arbiter onto a single-cycle-latency RAM data port.
// Grants are combinational; the owner of each access is remembered for one cycle to route its response.
module miriscv_data_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk_i,
  input  logic        arstn_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i,

  output logic        err_o
);

  localparam int NM = 2;

  logic [NM-1:0]       req, we, gnt, rvalid;
  logic [NM-1:0][3:0]  be;
  logic [NM-1:0][31:0] addr, wdata;

  logic gnt_id;
  logic last_q, last_d;
  logic pend_vld_q, pend_id_q;
  logic err_q, err_d;

  assign req   = {m1_req_i,   m0_req_i};
  assign we    = {m1_we_i,    m0_we_i};
  assign be    = {m1_be_i,    m0_be_i};
  assign addr  = {m1_addr_i,  m0_addr_i};
  assign wdata = {m1_wdata_i, m0_wdata_i};

  // On contention the master that did not win last time goes first; reset leaves last_q=1 so m0 wins first.
  always_comb begin
    gnt_id = req[1];
    if (req == 2'b11)
      gnt_id = ROUND_ROBIN ? ~last_q : 1'b0;
    gnt         = '0;
    gnt[gnt_id] = |req;
  end

  always_comb begin
    ram_req_o   = |gnt;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (|gnt) begin
      ram_we_o    = we[gnt_id];
      ram_be_o    = be[gnt_id];
      ram_addr_o  = addr[gnt_id];
      ram_wdata_o = wdata[gnt_id];
    end
  end

  assign last_d = (|gnt) ? gnt_id : last_q;

  // Any response without a pending owner, or any owner without a response, is a protocol error.
  assign err_d  = err_q | (ram_rvalid_i ^ pend_vld_q);
  assign rvalid = {pend_id_q, ~pend_id_q} & {NM{ram_rvalid_i & pend_vld_q}};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      last_q     <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_id_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      pend_vld_q <= ram_req_o;
      pend_id_q  <= gnt_id;
      err_q      <= err_d;
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_rdata_o  = ram_rdata_i;
  assign m1_rdata_o  = ram_rdata_i;
  assign err_o       = err_q;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for miriscv_data_arbiter: directed scenarios, then random traffic checked by a response scoreboard.
module tb_miriscv_data_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        err_o;

  logic        f_m0_gnt_o, f_m1_gnt_o, f_m0_rvalid_o, f_m1_rvalid_o;
  logic [31:0] f_m0_rdata_o, f_m1_rdata_o;
  logic        f_ram_req_o, f_ram_we_o;
  logic [3:0]  f_ram_be_o;
  logic [31:0] f_ram_addr_o, f_ram_wdata_o;
  logic        f_err_o;

  always #5 clk_i = ~clk_i;

  miriscv_data_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .err_o(err_o)
  );

  miriscv_data_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(f_m0_gnt_o), .m0_rvalid_o(f_m0_rvalid_o), .m0_rdata_o(f_m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(f_m1_gnt_o), .m1_rvalid_o(f_m1_rvalid_o), .m1_rdata_o(f_m1_rdata_o),
    .ram_req_o(f_ram_req_o), .ram_we_o(f_ram_we_o), .ram_be_o(f_ram_be_o), .ram_addr_o(f_ram_addr_o),
    .ram_wdata_o(f_ram_wdata_o), .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i),
    .err_o(f_err_o)
  );

  typedef struct {
    bit          id;
    logic [31:0] data;
  } resp_t;

  resp_t sbq[$];
  resp_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gnts();
    return {30'd0, m1_gnt_o, m0_gnt_o};
  endfunction

  function automatic logic [31:0] rvs();
    return {30'd0, m1_rvalid_o, m0_rvalid_o};
  endfunction

  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i); #1;
  endtask

  task automatic idle();
    m0_req_i = 0; m0_we_i = 0; m0_be_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
    ram_rvalid_i = 0; ram_rdata_i = 0;
  endtask

  // Reset with a stray RAM response present: no response may reach a master while in reset.
  task automatic do_reset();
    nxt();
    arstn_i = 1'b0;
    idle();
    ram_rvalid_i = 1'b1;
    smp();
    chk("rst_rvalid", rvs(), 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    nxt();
    idle();
    arstn_i = 1'b1;
  endtask

  // Monitor: each grant recorded in the scoreboard must come back to its owner exactly one cycle later.
  always @(negedge clk_i) begin
    if (mon_en && arstn_i) begin
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("rvalid_owner", rvs(), mon_e.id ? 32'd2 : 32'd1);
        chk("rdata", mon_e.id ? m1_rdata_o : m0_rdata_o, mon_e.data);
      end else begin
        chk("rvalid_idle", rvs(), 32'd0);
      end
    end
  end

  bit          p0, p1, gv, gid, last_m, nxt_rv;
  logic [31:0] nxt_rd;

  initial begin
    arstn_i = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);

    // single requester read
    do_reset();
    nxt(); m1_req_i = 1; m1_addr_i = 32'h10; smp();
    chk("single_gnt", gnts(), 32'd2);
    chk("single_addr", ram_addr_o, 32'h10);
    chk("single_we", {31'd0, ram_we_o}, 32'd0);
    nxt(); idle(); ram_rvalid_i = 1; ram_rdata_i = 32'hDEADBEEF; smp();
    chk("single_rvalid", rvs(), 32'd2);
    chk("single_rdata", m1_rdata_o, 32'hDEADBEEF);
    nxt(); idle(); smp();
    chk("single_err", {31'd0, err_o}, 32'd0);

    // contention: round-robin alternates, fixed priority always picks m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      nxt(); m0_req_i = 1; m1_req_i = 1; ram_rvalid_i = (i > 0); smp();
      chk("rr_gnt", gnts(), (i % 2) ? 32'd2 : 32'd1);
      chk("fp_gnt", {30'd0, f_m1_gnt_o, f_m0_gnt_o}, 32'd1);
      if (i > 0) chk("rr_rvalid", rvs(), ((i - 1) % 2) ? 32'd2 : 32'd1);
    end
    nxt(); idle(); ram_rvalid_i = 1; smp();
    chk("rr_rvalid_last", rvs(), 32'd2);
    nxt(); idle(); smp();
    chk("rr_err", {31'd0, err_o}, 32'd0);

    // write with byte enables
    do_reset();
    nxt(); m0_req_i = 1; m0_we_i = 1; m0_be_i = 4'b0011; m0_wdata_i = 32'h12345678; m0_addr_i = 32'h20; smp();
    chk("wr_gnt", gnts(), 32'd1);
    chk("wr_req", {31'd0, ram_req_o}, 32'd1);
    chk("wr_we", {31'd0, ram_we_o}, 32'd1);
    chk("wr_be", {28'd0, ram_be_o}, 32'h3);
    chk("wr_addr", ram_addr_o, 32'h20);
    chk("wr_wdata", ram_wdata_o, 32'h12345678);
    nxt(); idle(); ram_rvalid_i = 1; smp();
    chk("wr_rvalid", rvs(), 32'd1);

    // idle bus, then a spurious response makes err sticky until reset
    nxt(); idle(); smp();
    chk("idle_req", {31'd0, ram_req_o}, 32'd0);
    chk("idle_addr", ram_addr_o, 32'd0);
    nxt(); ram_rvalid_i = 1; smp();
    chk("spur_rvalid", rvs(), 32'd0);
    nxt(); idle(); smp();
    chk("spur_err", {31'd0, err_o}, 32'd1);
    nxt(); smp();
    chk("spur_err_hold", {31'd0, err_o}, 32'd1);
    do_reset();
    nxt(); smp();
    chk("spur_err_clr", {31'd0, err_o}, 32'd0);

    // missed response
    nxt(); m0_req_i = 1; smp();
    nxt(); idle(); smp();
    chk("miss_rvalid", rvs(), 32'd0);
    nxt(); smp();
    chk("miss_err", {31'd0, err_o}, 32'd1);

    // reset in the middle of an access drops the owner and the priority state
    do_reset();
    nxt(); m0_req_i = 1; smp();
    chk("mid_gnt", gnts(), 32'd1);
    nxt(); arstn_i = 0; idle(); ram_rvalid_i = 1; smp();
    chk("mid_rvalid", rvs(), 32'd0);
    nxt(); arstn_i = 1; ram_rvalid_i = 0; smp();
    chk("mid_err", {31'd0, err_o}, 32'd0);
    nxt(); m0_req_i = 1; m1_req_i = 1; smp();
    chk("mid_first_cont", gnts(), 32'd1);
    nxt(); idle(); ram_rvalid_i = 1; smp();
    chk("mid_resp", rvs(), 32'd1);

    // response right after reset release has no owner
    do_reset();
    nxt(); ram_rvalid_i = 1; smp();
    chk("post_rst_rvalid", rvs(), 32'd0);
    nxt(); idle(); smp();
    chk("post_rst_err", {31'd0, err_o}, 32'd1);

    // random traffic: masters hold a request until granted
    do_reset();
    p0 = 0; p1 = 0; last_m = 1; nxt_rv = 0; nxt_rd = 0;
    mon_en = 1'b1;
    for (int c = 0; c < 500; c++) begin
      nxt();
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; m0_we_i = 1'($urandom); m0_be_i = 4'($urandom);
        m0_addr_i = $urandom; m0_wdata_i = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; m1_we_i = 1'($urandom); m1_be_i = 4'($urandom);
        m1_addr_i = $urandom; m1_wdata_i = $urandom;
      end
      m0_req_i = p0; m1_req_i = p1;
      ram_rvalid_i = nxt_rv;
      ram_rdata_i  = nxt_rv ? nxt_rd : $urandom;
      smp();
      gv  = p0 | p1;
      gid = (p0 && p1) ? !last_m : p1;
      chk("rnd_gnt", gnts(), gv ? (gid ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd_fp_gnt", {30'd0, f_m1_gnt_o, f_m0_gnt_o}, p0 ? 32'd1 : (p1 ? 32'd2 : 32'd0));
      chk("rnd_req", {31'd0, ram_req_o}, {31'd0, gv});
      chk("rnd_addr", ram_addr_o, !gv ? 32'd0 : (gid ? m1_addr_i : m0_addr_i));
      chk("rnd_wdata", ram_wdata_o, !gv ? 32'd0 : (gid ? m1_wdata_i : m0_wdata_i));
      chk("rnd_attr", {27'd0, ram_we_o, ram_be_o},
          !gv ? 32'd0 : (gid ? {27'd0, m1_we_i, m1_be_i} : {27'd0, m0_we_i, m0_be_i}));
      chk("rnd_err", {31'd0, err_o}, 32'd0);
      if (gv) begin
        nxt_rd = $urandom;
        sbq.push_back('{id: gid, data: nxt_rd});
        last_m = gid;
        if (gid) p1 = 0; else p0 = 0;
      end
      nxt_rv = gv;
    end
    nxt(); idle(); ram_rvalid_i = nxt_rv; ram_rdata_i = nxt_rd; smp();
    nxt(); idle(); smp();
    mon_en = 1'b0;
    chk("sb_drain", sbq.size(), 32'd0);
    chk("final_err", {31'd0, err_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
